// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Read data returned on a watchdog-terminated cycle; sliced to DATA_WIDTH by users.
  localparam logic [255:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle for wb_bus_arbiter: both upstream masters plus the shared downstream port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface wb_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic [DATA_WIDTH-1:0] m0_data_i, m0_data_o;
  logic                  m0_ack_o;

  logic                  m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic [DATA_WIDTH-1:0] m1_data_i, m1_data_o;
  logic                  m1_ack_o;

  logic                  s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_WIDTH-1:0] s_addr_o;
  logic [DATA_WIDTH-1:0] s_data_o, s_data_i;
  logic                  s_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
    output m0_data_o, m0_ack_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
    output m1_data_o, m1_ack_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
    input  s_data_i, s_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
    input  m0_data_o, m0_ack_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
    input  m1_data_o, m1_ack_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
    output s_data_i, s_ack_i
  );
endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts consecutive stalled strobe cycles and raises a one-cycle
// expire pulse the cycle after the count reaches TIMEOUT_CYCLES-1.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;
  logic          expire_q, expire_d;

  // Any non-stalled cycle (ack, stb low, no owner) clears the count.
  always_comb begin
    count_d  = '0;
    expire_d = 1'b0;
    if (stall_i) begin
      if (count_q == LIMIT) expire_d = 1'b1;
      else                  count_d  = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;
endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter, round-robin per bus cycle, no preemption.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_bus_arbiter_if.slave bus,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_t state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       expire;

  logic                  s_cyc, s_stb, s_we, m0_ack, m1_ack;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_data, m0_data, m1_data;

  // Ties go to the master that did not own the bus last.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          state_d      = last_owner_q ? OWN0 : OWN1;
          last_owner_d = ~last_owner_q;
        end else if (bus.m0_cyc_i) begin
          state_d      = OWN0;
          last_owner_d = 1'b0;
        end else if (bus.m1_cyc_i) begin
          state_d      = OWN1;
          last_owner_d = 1'b1;
        end
      end
      OWN0:    if (!bus.m0_cyc_i) state_d = IDLE;
      OWN1:    if (!bus.m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Muxes decode the registered state only, so async reset drops them immediately.
  always_comb begin
    grant_o = 2'b00;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_data  = '0;
    m0_ack  = 1'b0;
    m0_data = '0;
    m1_ack  = 1'b0;
    m1_data = '0;
    unique case (state_q)
      OWN0: begin
        grant_o = 2'b01;
        s_cyc   = bus.m0_cyc_i;
        s_stb   = bus.m0_stb_i & ~expire;
        s_we    = bus.m0_we_i;
        s_addr  = bus.m0_addr_i;
        s_data  = bus.m0_data_i;
        m0_ack  = bus.s_ack_i | expire;
        m0_data = expire ? TIMEOUT_DATA[DATA_WIDTH-1:0] : bus.s_data_i;
      end
      OWN1: begin
        grant_o = 2'b10;
        s_cyc   = bus.m1_cyc_i;
        s_stb   = bus.m1_stb_i & ~expire;
        s_we    = bus.m1_we_i;
        s_addr  = bus.m1_addr_i;
        s_data  = bus.m1_data_i;
        m1_ack  = bus.s_ack_i | expire;
        m1_data = expire ? TIMEOUT_DATA[DATA_WIDTH-1:0] : bus.s_data_i;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall_i  ((state_q != IDLE) & s_stb & ~bus.s_ack_i),
    .expire_o (expire)
  );
  assign timeout_o = expire & (state_q != IDLE);
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign bus.s_cyc_o   = s_cyc;
  assign bus.s_stb_o   = s_stb;
  assign bus.s_we_o    = s_we;
  assign bus.s_addr_o  = s_addr;
  assign bus.s_data_o  = s_data;
  assign bus.m0_ack_o  = m0_ack;
  assign bus.m0_data_o = m0_data;
  assign bus.m1_ack_o  = m1_ack;
  assign bus.m1_data_o = m1_data;
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Randomised and directed bench for wb_bus_arbiter against a transaction-level owner model.
module tb_wb_bus_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TC = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       timeout;

  wb_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  wb_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grant_o(grant), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: who owns the bus (-1 none), who owned it last, consecutive stalled strobes.
  int m_owner, m_last, m_stall;
  bit m_pend;

  typedef logic [135:0] vec_t;

  function automatic vec_t dut_vec();
    return {grant, timeout, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o,
            bus.m0_ack_o, bus.m0_data_o, bus.m1_ack_o, bus.m1_data_o};
  endfunction

  function automatic vec_t exp_vec();
    logic [1:0]    g = 2'b00;
    logic          to, cyc = 1'b0, stb = 1'b0, we = 1'b0, k0 = 1'b0, k1 = 1'b0;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] d = '0, r0 = '0, r1 = '0;
    to = WD && m_pend && (m_owner >= 0);
    if (m_owner == 0) begin
      g = 2'b01; cyc = bus.m0_cyc_i; stb = bus.m0_stb_i && !to; we = bus.m0_we_i;
      a = bus.m0_addr_i; d = bus.m0_data_i;
      k0 = bus.s_ack_i || to; r0 = to ? {DW{1'b1}} : bus.s_data_i;
    end else if (m_owner == 1) begin
      g = 2'b10; cyc = bus.m1_cyc_i; stb = bus.m1_stb_i && !to; we = bus.m1_we_i;
      a = bus.m1_addr_i; d = bus.m1_data_i;
      k1 = bus.s_ack_i || to; r1 = to ? {DW{1'b1}} : bus.s_data_i;
    end
    return {g, to, cyc, stb, we, a, d, k0, r0, k1, r1};
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_last = 1; m_stall = 0; m_pend = 1'b0;
  endfunction

  function automatic void model_edge();
    bit ostb, to, stalled, c0, c1;
    c0 = bus.m0_cyc_i; c1 = bus.m1_cyc_i;
    ostb = (m_owner == 0) ? bus.m0_stb_i : (m_owner == 1) ? bus.m1_stb_i : 1'b0;
    to = WD && m_pend && (m_owner >= 0);
    stalled = (m_owner >= 0) && ostb && !to && !bus.s_ack_i;
    m_stall = stalled ? m_stall + 1 : 0;
    m_pend = WD && (m_stall == TC);
    if (m_owner < 0) begin
      if (c0 && c1) m_owner = 1 - m_last;
      else if (c0)  m_owner = 0;
      else if (c1)  m_owner = 1;
      if (m_owner >= 0) m_last = m_owner;
    end else if ((m_owner == 0 && !c0) || (m_owner == 1 && !c1)) begin
      m_owner = -1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_m0(input bit c, input bit s, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m0_cyc_i = c; bus.m0_stb_i = s; bus.m0_we_i = w; bus.m0_addr_i = a; bus.m0_data_i = d;
  endtask

  task automatic set_m1(input bit c, input bit s, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m1_cyc_i = c; bus.m1_stb_i = s; bus.m1_we_i = w; bus.m1_addr_i = a; bus.m1_data_i = d;
  endtask

  task automatic set_s(input bit k, input logic [DW-1:0] d);
    bus.s_ack_i = k; bus.s_data_i = d;
  endtask

  task automatic do_reset();
    set_m0(0, 0, 0, '0, '0); set_m1(0, 0, 0, '0, '0); set_s(0, '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_m0(0, 0, 0, '0, '0); set_m1(0, 0, 0, '0, '0); set_s(0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    do_reset();
    @(negedge clk);
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_m0(k < 4, k < 4, 0, 32'h0000_0010, '0);
      set_s(k == 3, (k == 3) ? 32'h1234_5678 : 32'h0);
      @(negedge clk);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL single k%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (k == 1) begin
        vectors++;
        if (grant !== 2'b01) begin miscompares++; $display("FAIL single_grant: got %b want 01", grant); end
      end
      if (k == 3) begin
        vectors++;
        if ({bus.m0_ack_o, bus.m0_data_o, bus.m1_ack_o} !== {1'b1, 32'h1234_5678, 1'b0}) begin
          miscompares++;
          $display("FAIL single_read: got ack %b data %h m1ack %b want 1 12345678 0",
                   bus.m0_ack_o, bus.m0_data_o, bus.m1_ack_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_tie_after_reset();
    logic [1:0] want [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_m0(k < 3, k < 3, 1, 32'hA0, 32'h11); set_m1(1, 1, 0, 32'hB0, 32'h22); set_s(0, '0);
      @(negedge clk);
      vectors++;
      if (grant !== want[k] || dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL tie k%0d: got grant %b want %b (vec %h vs %h)", k, grant, want[k], dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [1:0] seq [40];
    int held0 = 0, held1 = 0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      set_m0(!(grant == 2'b01 && held0 >= 2), 1, 0, 32'h100 + k, '0);
      set_m1(!(grant == 2'b10 && held1 >= 2), 1, 0, 32'h200 + k, '0);
      set_s(1, 32'h5A5A_0000 + k);
      @(negedge clk);
      seq[k] = grant;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL fair_model k%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      tick();
      held0 = (grant == 2'b01) ? held0 + 1 : 0;
      held1 = (grant == 2'b10) ? held1 + 1 : 0;
    end
    for (int k = 2; k < 39; k++) begin
      if (seq[k] == 2'b00) begin
        vectors++;
        if (seq[k-1] == 2'b00 || seq[k+1] !== {seq[k-1][0], seq[k-1][1]}) begin
          miscompares++; $display("FAIL fair_alternate k%0d: got %b,%b,%b want owner swap", k, seq[k-1], seq[k], seq[k+1]);
        end
      end
    end
  endtask

  task automatic test_no_preempt();
    logic [AW-1:0] a0, want;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      a0 = 32'h100 + 4 * ((k < 1) ? 0 : (k > 4) ? 3 : k - 1);
      set_m0(k < 5, k < 5, 1, a0, 32'hC0DE_0000 + k);
      set_m1(k >= 1, k >= 1, 0, 32'hDEAD_0000, '0);
      set_s(1, 32'h0);
      @(negedge clk);
      want = (k >= 1 && k <= 5) ? a0 : (k >= 7) ? 32'hDEAD_0000 : '0;
      vectors++;
      if (bus.s_addr_o !== want || dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL no_preempt k%0d: got addr %h want %h", k, bus.s_addr_o, want);
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    int first_ack = -1, pulses = 0, cycles;
    do_reset();
    cycles = WD ? 16 : 100;
    for (int k = 0; k < cycles; k++) begin
      set_m0(!(WD && k >= 10), !(WD && k >= 10), 0, 32'h40, '0);
      set_s(0, 32'h0BAD_0BAD);
      @(negedge clk);
      if (bus.m0_ack_o === 1'b1 && first_ack < 0) first_ack = k;
      if (timeout === 1'b1) pulses++;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL watchdog k%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (WD && k == 9) begin
        vectors++;
        if ({bus.m0_ack_o, bus.m0_data_o, timeout, bus.s_stb_o} !== {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL watchdog_expire: got ack %b data %h to %b stb %b want 1 ffffffff 1 0",
                   bus.m0_ack_o, bus.m0_data_o, timeout, bus.s_stb_o);
        end
      end
      tick();
    end
    vectors++;
    if (WD ? (first_ack != 9 || pulses != 1) : (first_ack != -1 || pulses != 0)) begin
      miscompares++; $display("FAIL watchdog_summary: got first_ack %0d pulses %0d", first_ack, pulses);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_m1(1, 1, 1, 32'h300, 32'h77); set_s(k == 2, 32'h99);
      if (k < 2) tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.s_cyc_o, grant, bus.m1_ack_o} !== 4'b0) begin
      miscompares++; $display("FAIL async_reset: got cyc %b grant %b ack %b want 0", bus.s_cyc_o, grant, bus.m1_ack_o);
    end
    model_reset();
    @(posedge clk); #1;
    set_m0(1, 1, 0, 32'h500, '0); set_m1(1, 1, 0, 32'h600, '0); set_s(0, '0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if (grant !== 2'b01 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL async_reset_tie: got grant %b want 01", grant);
    end
    tick();
  endtask

  task automatic test_random();
    bit c0 = 0, c1 = 0;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) c0 = ~c0;
      if ($urandom_range(0, 5) == 0) c1 = ~c1;
      set_m0(c0, c0 && ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom, $urandom);
      set_m1(c1, c1 && ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom, $urandom);
      set_s(((k / 150) % 2 == 1) ? 1'b0 : ($urandom_range(0, 2) == 0), $urandom);
      @(negedge clk);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL random k%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_tie_after_reset();
    test_fairness();
    test_no_preempt();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
